// File: rtl/pixel_fetch_if.sv
// pixel_fetch_if -- bundles the raster, sprite, ROM and palette-index
// signals of pixel_fetch so the pipeline has a single bus port.
//   Raster in  : DrawX, DrawY, de_in, hs_in, vs_in, scene
//   Sprite in  : player_x, player_y, player_frame
//   ROM        : bg_rom_addr/sprite_rom_addr out, bg_rom_data/sprite_rom_data in
//   Palette out: select, palette_color, map_palette_color,
//                gym_palette_color, start_palette_color
//   Timing out : de_out, hs_out, vs_out
// master = raster source / ROM model side, slave = pixel_fetch.
interface pixel_fetch_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        de_in;
  logic        hs_in;
  logic        vs_in;
  logic [1:0]  scene;
  logic [9:0]  player_x;
  logic [9:0]  player_y;
  logic [1:0]  player_frame;
  logic [16:0] bg_rom_addr;
  logic [9:0]  sprite_rom_addr;
  logic [7:0]  bg_rom_data;
  logic [3:0]  sprite_rom_data;
  logic [2:0]  select;
  logic [3:0]  palette_color;
  logic [7:0]  map_palette_color;
  logic [5:0]  gym_palette_color;
  logic [4:0]  start_palette_color;
  logic        de_out;
  logic        hs_out;
  logic        vs_out;

  modport master (
    output DrawX, DrawY, de_in, hs_in, vs_in, scene,
           player_x, player_y, player_frame, bg_rom_data, sprite_rom_data,
    input  bg_rom_addr, sprite_rom_addr, select, palette_color,
           map_palette_color, gym_palette_color, start_palette_color,
           de_out, hs_out, vs_out
  );

  modport slave (
    input  DrawX, DrawY, de_in, hs_in, vs_in, scene,
           player_x, player_y, player_frame, bg_rom_data, sprite_rom_data,
    output bg_rom_addr, sprite_rom_addr, select, palette_color,
           map_palette_color, gym_palette_color, start_palette_color,
           de_out, hs_out, vs_out
  );
endinterface

// File: rtl/pixel_fetch.sv
// pixel_fetch -- three-stage pixel pipeline feeding the palette lookup.
//   Clk   : single clock
//   Reset : synchronous, active-high
//   bus   : pixel_fetch_if.slave (raster in, ROM address/data, palette
//           select/index out, delayed de/hs/vs out)
// Stage 1 registers ROM addresses, sprite hit and the effective scene from
// the scene FSM; stage 2 waits for the synchronous ROMs; stage 3 composites
// sprite over background. One pixel per cycle, 3 cycles latency.
module pixel_fetch (
  input logic          Clk,
  input logic          Reset,
  pixel_fetch_if.slave bus
);

  typedef enum logic [1:0] {SHOW, DRAIN, BLACK} state_t;

  localparam logic [1:0] SC_MAP   = 2'd0;
  localparam logic [1:0] SC_GYM   = 2'd1;
  localparam logic [1:0] SC_START = 2'd2;
  localparam logic [1:0] SC_BLACK = 2'd3;

  localparam logic [2:0] SEL_SPRITE = 3'd0;
  localparam logic [2:0] SEL_MAP    = 3'd1;
  localparam logic [2:0] SEL_GYM    = 3'd2;
  localparam logic [2:0] SEL_START  = 3'd3;
  localparam logic [2:0] SEL_BLANK  = 3'd4;

  state_t      state;
  logic [1:0]  cur_scene;
  logic        frame_start;
  logic [1:0]  eff_scene;

  logic [10:0] x_ext, y_ext, px_lo, py_lo, px_hi, py_hi;
  logic        hit;
  logic [3:0]  dx, dy;
  logic [16:0] x_half, y_half;

  logic        hit1, de1, hs1, vs1;
  logic [1:0]  scene1;
  logic        hit2, de2, hs2, vs2;
  logic [1:0]  scene2;

  assign frame_start = (bus.DrawX == 10'd0) && (bus.DrawY == 10'd0);

  // Sprite bounds at 11 bits so player_x + 15 cannot wrap past 1023.
  assign x_ext = {1'b0, bus.DrawX};
  assign y_ext = {1'b0, bus.DrawY};
  assign px_lo = {1'b0, bus.player_x};
  assign py_lo = {1'b0, bus.player_y};
  assign px_hi = px_lo + 11'd15;
  assign py_hi = py_lo + 11'd15;
  assign hit   = (x_ext >= px_lo) && (x_ext <= px_hi) &&
                 (y_ext >= py_lo) && (y_ext <= py_hi);

  // Low nibble of a difference only depends on the low nibbles.
  assign dx = bus.DrawX[3:0] - bus.player_x[3:0];
  assign dy = bus.DrawY[3:0] - bus.player_y[3:0];

  // (y/2)*320 = (y/2)*256 + (y/2)*64, kept in 17 bits.
  assign x_half = {7'd0, bus.DrawX} >> 1;
  assign y_half = {7'd0, bus.DrawY} >> 1;

  // The scene shown for the pixel entering now. A BLACK frame-start pixel
  // already shows the newly loaded scene; a mismatch in SHOW blanks at once.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    eff_scene = SC_BLACK;
    case (state)
      SHOW:    eff_scene = (bus.scene == cur_scene) ? cur_scene : SC_BLACK;
      DRAIN:   eff_scene = SC_BLACK;
      BLACK:   eff_scene = frame_start ? cur_scene : SC_BLACK;
      default: eff_scene = SC_BLACK;
    endcase
  end

  // Scene FSM: DRAIN waits for a frame start to load the new scene, then
  // BLACK blanks one full frame before returning to SHOW.
  // NOTE: state is updated with non-blocking assignments so every reader in
  // this cycle sees the pre-edge value, matching real flops.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= SHOW;
      cur_scene <= SC_START;
    end else begin
      case (state)
        SHOW:  if (bus.scene != cur_scene) state <= DRAIN;
        DRAIN: if (frame_start) begin
                 cur_scene <= bus.scene;
                 state     <= BLACK;
               end
        BLACK: if (frame_start) state <= SHOW;
        default: state <= SHOW;
      endcase
    end
  end

  // Stage 1: ROM addresses and per-pixel attributes.
  // NOTE: reset is synchronous and clears every pipeline flop, so a reset
  // mid-frame flushes all in-flight pixels.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bus.bg_rom_addr     <= '0;
      bus.sprite_rom_addr <= '0;
      hit1   <= 1'b0;
      de1    <= 1'b0;
      hs1    <= 1'b0;
      vs1    <= 1'b0;
      scene1 <= '0;
    end else begin
      bus.bg_rom_addr     <= (y_half << 8) + (y_half << 6) + x_half;
      bus.sprite_rom_addr <= hit ? {bus.player_frame, dy, dx} : 10'd0;
      hit1   <= hit;
      de1    <= bus.de_in;
      hs1    <= bus.hs_in;
      vs1    <= bus.vs_in;
      scene1 <= eff_scene;
    end
  end

  // Stage 2: align attributes with the ROM data arriving next cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hit2   <= 1'b0;
      de2    <= 1'b0;
      hs2    <= 1'b0;
      vs2    <= 1'b0;
      scene2 <= '0;
    end else begin
      hit2   <= hit1;
      de2    <= de1;
      hs2    <= hs1;
      vs2    <= vs1;
      scene2 <= scene1;
    end
  end

  // Stage 3: composite. Unused indices stay 0; sprite index 0 is transparent
  // and the start screen never draws the sprite.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bus.select              <= SEL_BLANK;
      bus.palette_color       <= '0;
      bus.map_palette_color   <= '0;
      bus.gym_palette_color   <= '0;
      bus.start_palette_color <= '0;
      bus.de_out              <= 1'b0;
      bus.hs_out              <= 1'b0;
      bus.vs_out              <= 1'b0;
    end else begin
      bus.select              <= SEL_BLANK;
      bus.palette_color       <= '0;
      bus.map_palette_color   <= '0;
      bus.gym_palette_color   <= '0;
      bus.start_palette_color <= '0;
      bus.de_out              <= de2;
      bus.hs_out              <= hs2;
      bus.vs_out              <= vs2;
      if (de2) begin
        case (scene2)
          SC_MAP, SC_GYM: begin
            if (hit2 && (bus.sprite_rom_data != 4'd0)) begin
              bus.select        <= SEL_SPRITE;
              bus.palette_color <= bus.sprite_rom_data;
            end else if (scene2 == SC_MAP) begin
              bus.select            <= SEL_MAP;
              bus.map_palette_color <= bus.bg_rom_data;
            end else begin
              bus.select            <= SEL_GYM;
              bus.gym_palette_color <= bus.bg_rom_data[5:0];
            end
          end
          SC_START: begin
            bus.select              <= SEL_START;
            bus.start_palette_color <= bus.bg_rom_data[4:0];
          end
          default: bus.select <= SEL_BLANK;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pixel_fetch.sv
// tb_pixel_fetch -- self-checking bench for pixel_fetch. Drives one pixel per
// cycle on the falling edge, models both ROMs as synchronous memories, and
// compares every output against a frame-level reference model.
module tb_pixel_fetch;

  localparam int MAXC = 8000;

  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] pal;
    logic [7:0] map;
    logic [5:0] gym;
    logic [4:0] start;
    logic       de;
    logic       hs;
    logic       vs;
  } comp_t;

  typedef struct packed {
    logic [16:0] bg;
    logic [9:0]  sp;
    comp_t       c;
  } exp_t;

  typedef struct {
    logic [1:0] scene;
    int         x, y, px, py;
    logic [1:0] fr;
    logic       de, hs, vs;
    logic [7:0] bg;
    logic [3:0] spr;
    logic [2:0] sel;
    logic [7:0] val;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pixel_fetch_if bus();
  pixel_fetch dut (.Clk(clk), .Reset(reset), .bus(bus.slave));

  logic [7:0] bg_mem [0:131071];
  logic [3:0] sp_mem [0:1023];

  always @(posedge clk) begin
    bus.bg_rom_data     <= bg_mem[bus.bg_rom_addr];
    bus.sprite_rom_data <= sp_mem[bus.sprite_rom_addr];
  end

  exp_t        exp_a    [MAXC];
  comp_t       act_comp [MAXC];
  logic [26:0] act_addr [MAXC];
  int n = 0;
  int checks = 0;
  int errors = 0;

  // Reference model state: frame starts still to pass before the shown
  // scene is visible again (0 = visible), and the scene being shown.
  int         m_left = 0;
  logic [1:0] m_shown = 2'd2;

  vec_t tbl [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic exp_t rst_exp();
    exp_t e;
    e = '0;
    e.c.sel = 3'd4;
    return e;
  endfunction

  function automatic comp_t mk(input logic [2:0] sel, input logic [7:0] val,
                               input logic de, input logic hs, input logic vs);
    comp_t c;
    c = '0;
    c.sel = sel;
    c.de = de; c.hs = hs; c.vs = vs;
    case (sel)
      3'd0: c.pal   = val[3:0];
      3'd1: c.map   = val;
      3'd2: c.gym   = val[5:0];
      3'd3: c.start = val[4:0];
      default: ;
    endcase
    return c;
  endfunction

  function automatic bit is_hit(input int x, input int y, input int px, input int py);
    return (x >= px) && (x <= px + 15) && (y >= py) && (y <= py + 15);
  endfunction

  task automatic model(input int x, input int y, input logic de, input logic hs,
                       input logic vs, input logic [1:0] sc, input int px,
                       input int py, input logic [1:0] fr, output exp_t e);
    bit hit, black;
    int bga, spa;
    logic [1:0] eff;
    logic [7:0] bgv;
    logic [3:0] spv;
    black = 1'b1;
    eff = 2'd3;
    if (m_left == 0) begin
      if (sc != m_shown) m_left = 2;
      else begin black = 1'b0; eff = m_shown; end
    end else if (x == 0 && y == 0) begin
      m_left--;
      if (m_left == 1) m_shown = sc;
      else begin black = 1'b0; eff = m_shown; end
    end
    hit = is_hit(x, y, px, py);
    bga = (y / 2) * 320 + x / 2;
    spa = hit ? int'(fr) * 256 + (y - py) * 16 + (x - px) : 0;
    bgv = bg_mem[bga];
    spv = sp_mem[spa];
    e = '0;
    e.bg = 17'(bga);
    e.sp = 10'(spa);
    e.c = mk(3'd4, 8'd0, de, hs, vs);
    if (de && !black && eff != 2'd3) begin
      if (eff != 2'd2 && hit && spv != 4'd0) e.c = mk(3'd0, {4'd0, spv}, de, hs, vs);
      else if (eff == 2'd0) e.c = mk(3'd1, bgv, de, hs, vs);
      else if (eff == 2'd1) e.c = mk(3'd2, bgv, de, hs, vs);
      else e.c = mk(3'd3, bgv, de, hs, vs);
    end
  endtask

  // One cycle: check what is due at this falling edge, then drive a pixel.
  task automatic step(input logic rst, input int x, input int y, input logic de,
                      input logic hs, input logic vs, input logic [1:0] sc,
                      input int px, input int py, input logic [1:0] fr);
    comp_t c;
    if (n >= MAXC) begin
      $display("FAIL cycle_budget: used %0d of %0d", n, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    @(negedge clk);
    if (n >= 1) begin
      act_addr[n-1] = {bus.bg_rom_addr, bus.sprite_rom_addr};
      check($sformatf("addr@%0d", n-1), 64'(act_addr[n-1]),
            64'({exp_a[n-1].bg, exp_a[n-1].sp}));
    end
    if (n >= 3) begin
      c.sel = bus.select;  c.pal = bus.palette_color;
      c.map = bus.map_palette_color;  c.gym = bus.gym_palette_color;
      c.start = bus.start_palette_color;
      c.de = bus.de_out;  c.hs = bus.hs_out;  c.vs = bus.vs_out;
      act_comp[n-3] = c;
      check($sformatf("pix@%0d", n-3), 64'(c), 64'(exp_a[n-3].c));
    end
    reset = rst;
    bus.DrawX = 10'(x);  bus.DrawY = 10'(y);
    bus.de_in = de;  bus.hs_in = hs;  bus.vs_in = vs;
    bus.scene = sc;
    bus.player_x = 10'(px);  bus.player_y = 10'(py);  bus.player_frame = fr;
    if (rst) begin
      m_left = 0;
      m_shown = 2'd2;
      for (int k = n - 2; k <= n; k++) if (k >= 0) exp_a[k] = rst_exp();
    end else begin
      model(x, y, de, hs, vs, sc, px, py, fr, exp_a[n]);
    end
    n++;
  endtask

  task automatic idle(input logic [1:0] sc, input int cnt);
    for (int i = 0; i < cnt; i++) step(1'b0, 1, 1, 1'b0, 1'b0, 1'b0, sc, 600, 400, 2'd0);
  endtask

  task automatic apply_table(input logic [1:0] sc);
    int bga, spa, nv;
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].scene == sc) begin
        bga = (tbl[i].y / 2) * 320 + tbl[i].x / 2;
        spa = is_hit(tbl[i].x, tbl[i].y, tbl[i].px, tbl[i].py)
              ? int'(tbl[i].fr) * 256 + (tbl[i].y - tbl[i].py) * 16 + (tbl[i].x - tbl[i].px) : 0;
        bg_mem[bga] = tbl[i].bg;
        if (spa != 0) sp_mem[spa] = tbl[i].spr;
        nv = n;
        step(1'b0, tbl[i].x, tbl[i].y, tbl[i].de, tbl[i].hs, tbl[i].vs, sc,
             tbl[i].px, tbl[i].py, tbl[i].fr);
        idle(sc, 3);
        check($sformatf("tbl%0d_pix", i), 64'(act_comp[nv]),
              64'(mk(tbl[i].sel, tbl[i].val, tbl[i].de, tbl[i].hs, tbl[i].vs)));
        check($sformatf("tbl%0d_addr", i), 64'(act_addr[nv]), 64'({17'(bga), 10'(spa)}));
      end
    end
  endtask

  initial begin
    int nd, nf1, nf2, nr, na, x, y, px, py;
    logic [1:0] cur_sc;

    //                scene x    y    px   py   fr    de    hs    vs    bg     spr    sel   val
    tbl[0]  = '{2'd2, 10,  6,   300, 300, 2'd0, 1'b1, 1'b0, 1'b0, 8'h07, 4'h0, 3'd3, 8'h07};
    tbl[1]  = '{2'd2, 305, 302, 300, 300, 2'd1, 1'b1, 1'b1, 1'b0, 8'hAB, 4'h9, 3'd3, 8'h0B};
    tbl[2]  = '{2'd2, 639, 479, 300, 300, 2'd0, 1'b0, 1'b0, 1'b1, 8'h5A, 4'h0, 3'd4, 8'h00};
    tbl[3]  = '{2'd1, 20,  20,  18,  19,  2'd3, 1'b1, 1'b0, 1'b0, 8'h55, 4'hC, 3'd0, 8'h0C};
    tbl[4]  = '{2'd1, 20,  20,  18,  19,  2'd3, 1'b1, 1'b0, 1'b1, 8'hFF, 4'h0, 3'd2, 8'h3F};
    tbl[5]  = '{2'd1, 17,  20,  18,  19,  2'd3, 1'b1, 1'b0, 1'b0, 8'h42, 4'h0, 3'd2, 8'h02};
    tbl[6]  = '{2'd0, 103, 52,  100, 50,  2'd2, 1'b1, 1'b0, 1'b0, 8'h11, 4'h5, 3'd0, 8'h05};
    tbl[7]  = '{2'd0, 103, 52,  100, 50,  2'd2, 1'b1, 1'b0, 1'b0, 8'h99, 4'h0, 3'd1, 8'h99};
    tbl[8]  = '{2'd0, 115, 65,  100, 50,  2'd0, 1'b1, 1'b1, 1'b1, 8'h31, 4'h3, 3'd0, 8'h03};
    tbl[9]  = '{2'd0, 116, 50,  100, 50,  2'd0, 1'b1, 1'b0, 1'b0, 8'h77, 4'h0, 3'd1, 8'h77};
    tbl[10] = '{2'd0, 5,   10,  630, 5,   2'd1, 1'b1, 1'b0, 1'b0, 8'h21, 4'h0, 3'd1, 8'h21};
    tbl[11] = '{2'd0, 635, 8,   630, 5,   2'd1, 1'b1, 1'b0, 1'b0, 8'h44, 4'h6, 3'd0, 8'h06};
    tbl[12] = '{2'd0, 50,  50,  600, 400, 2'd0, 1'b0, 1'b1, 1'b1, 8'h88, 4'h0, 3'd4, 8'h00};

    for (int i = 0; i < 131072; i++) bg_mem[i] = 8'($urandom);
    for (int i = 0; i < 1024; i++)
      sp_mem[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));

    // Reset, then start-screen vectors.
    step(1'b1, 1, 1, 1'b0, 1'b0, 1'b0, 2'd2, 600, 400, 2'd0);
    step(1'b1, 1, 1, 1'b0, 1'b0, 1'b0, 2'd2, 600, 400, 2'd0);
    apply_table(2'd2);

    // Start -> gym mid-frame: blank through drain and one full frame.
    nd = n;
    for (int i = 0; i < 3; i++) step(1'b0, 100 + i, 100, 1'b1, 1'b0, 1'b0, 2'd1, 600, 400, 2'd0);
    nf1 = n;
    step(1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 2'd1, 600, 400, 2'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 5 + i, 5, 1'b1, 1'b0, 1'b0, 2'd1, 600, 400, 2'd0);
    nf2 = n;
    step(1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 2'd1, 600, 400, 2'd0);
    step(1'b0, 1, 0, 1'b1, 1'b0, 1'b0, 2'd1, 600, 400, 2'd0);
    idle(2'd1, 3);
    check("gym_detect_blank", 64'(act_comp[nd].sel), 64'(3'd4));
    check("gym_drain_fs_blank", 64'(act_comp[nf1].sel), 64'(3'd4));
    check("gym_black_last", 64'(act_comp[nf2-1].sel), 64'(3'd4));
    check("gym_first_pixel", 64'(act_comp[nf2].sel), 64'(3'd2));
    check("gym_second_pixel", 64'(act_comp[nf2+1].sel), 64'(3'd2));
    apply_table(2'd1);

    // Gym -> map with the change landing on a frame start.
    nd = n;
    step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 2'd0, 600, 400, 2'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 7, 3, 1'b1, 1'b0, 1'b0, 2'd0, 600, 400, 2'd0);
    nf1 = n;
    step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 2'd0, 600, 400, 2'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 7, 3, 1'b1, 1'b0, 1'b0, 2'd0, 600, 400, 2'd0);
    nf2 = n;
    step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 2'd0, 600, 400, 2'd0);
    idle(2'd0, 3);
    check("map_fs_change_blank", 64'(act_comp[nd].sel), 64'(3'd4));
    check("map_second_fs_blank", 64'(act_comp[nf1].sel), 64'(3'd4));
    check("map_visible", 64'(act_comp[nf2].sel), 64'(3'd1));
    apply_table(2'd0);

    // Reset while draining back towards the start screen.
    step(1'b0, 50, 50, 1'b1, 1'b0, 1'b0, 2'd2, 600, 400, 2'd0);
    step(1'b0, 51, 50, 1'b1, 1'b0, 1'b0, 2'd2, 600, 400, 2'd0);
    nr = n;
    step(1'b1, 52, 50, 1'b1, 1'b0, 1'b0, 2'd2, 600, 400, 2'd0);
    na = n;
    step(1'b0, 53, 50, 1'b1, 1'b0, 1'b0, 2'd2, 600, 400, 2'd0);
    idle(2'd2, 3);
    check("rst_flush_sel", 64'(act_comp[nr-2].sel), 64'(3'd4));
    check("rst_flush_de", 64'(act_comp[nr-2].de), 64'(1'b0));
    check("rst_start_shown", 64'(act_comp[na].sel), 64'(3'd3));

    // Randomized traffic with short pseudo-frames.
    cur_sc = 2'd2;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) cur_sc = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) begin x = 0; y = 0; end
      else begin x = $urandom_range(0, 639); y = $urandom_range(0, 479); end
      if ($urandom_range(0, 1) == 1) begin
        px = x - int'($urandom_range(0, 17));  py = y - int'($urandom_range(0, 17));
        if (px < 0) px = 0;
        if (py < 0) py = 0;
      end else begin
        px = $urandom_range(0, 639);  py = $urandom_range(0, 479);
      end
      step(($urandom_range(0, 699) == 0), x, y, ($urandom_range(0, 4) != 0),
           1'($urandom), 1'($urandom), cur_sc, px, py, 2'($urandom));
    end
    idle(cur_sc, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
